seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised serial bit-pattern detector, successor to the fixed 4-bit FSM detector.
//   Adds runtime-loadable pattern and don't-care mask, input-valid qualification, and
//   selectable overlapping/non-overlapping matching. Adds a saturating match counter.
//   Sits on a serial bit stream; detected_o feeds downstream control/interrupt logic.
// PARAMETERS
//   PAT_W        4        pattern length in bits, legal 2..32
//   CNT_W        8        match counter width, legal >=1
//   DEFAULT_PAT  4'b1011  pattern after reset, PAT_W bits wide; reset mask is all ones
// PORTS
//   clk         in   1      clock, all state on posedge
//   reset_i     in   1      synchronous, active-high reset
//   valid_i     in   1      in_i is a valid stream bit this cycle
//   in_i        in   1      serial data bit
//   overlap_i   in   1      1=overlapping matches, 0=history cleared after each match
//   pat_load_i  in   1      load pat_i/mask_i this cycle
//   pat_i       in   PAT_W  new pattern; MSB = oldest bit of sequence
//   mask_i      in   PAT_W  1=compare bit, 0=don't care
//   clr_cnt_i   in   1      clear match counter
//   detected_o  out  1      one-cycle match pulse
//   armed_o     out  1      history holds PAT_W valid bits (state ARMED)
//   match_cnt_o out  CNT_W  saturating count of matches
// BEHAVIOUR
//   Reset (sync, highest priority): pat=DEFAULT_PAT, mask='1, hist=0, fill=0, state=FILL.
//     Outputs after reset: detected_o=0, armed_o=0, match_cnt_o=0.
//   History: on valid beat, nxt={hist[PAT_W-2:0],in_i}. New bit enters the LSB.
//     fill counts valid bits held, saturating at PAT_W.
//   Match on a valid beat when (fill+1>=PAT_W) && (((nxt^pat)&mask)==0).
//   Latency: detected_o=1 for exactly the cycle after the completing valid beat, else 0.
//   mask=0 -> every valid beat matches once armed. This is legal, not an error.
//   FSM states:
//     FILL  : fill<PAT_W. -> ARMED when a valid beat brings fill to PAT_W with no match.
//     ARMED : fill==PAT_W. Stays ARMED on a valid beat with no match.
//   Match handling (either state):
//     overlap_i=1 -> hist=nxt, state ARMED.
//     overlap_i=0 -> hist=0, fill=0, state FILL. The next match needs PAT_W fresh bits.
//     overlap_i is sampled on the match beat only.
//   valid_i=0 -> hist, fill, state and count hold; detected_o=0 next cycle.
//   pat_load_i=1 (priority over valid_i):
//     pat/mask <= pat_i/mask_i; hist=0, fill=0, state FILL.
//     That cycle's in_i is discarded; detected_o=0 next cycle.
//   armed_o = (state==ARMED), registered.
//   Counter:
//     Increments on the same edge that sets detected_o; saturates at 2^CNT_W-1, no wrap.
//     clr_cnt_i alone -> 0.
//     clr_cnt_i with a match in the same cycle -> 1 (clear first, then count the match).
//   Reset mid-pattern: partial history is lost; no detect from bits before reset.
// TESTING
//   1 Defaults, overlap_i=0, bits 1,0,1,1,0,1,1 on consecutive valid beats
//     -> detected_o pulses once, cycle after beat 4; match_cnt_o=1.
//   2 Same stream with overlap_i=1 -> pulses after beats 4 and 7; match_cnt_o=2;
//     armed_o=1 from the cycle after beat 4.
//   3 Bits 1,0,1,1 with valid_i=0 for 2 cycles between each bit
//     -> single pulse, cycle after the 4th valid beat; no pulse during gaps.
//   4 Load pat=4'b1001, mask=4'b1101; stream 1001 then 1011 with overlap_i=0
//     -> two pulses. Stream 0001 -> no pulse.
//     Load with valid_i=1, in_i=1 -> that bit ignored; armed_o=0.
//   5 CNT_W=2, mask=0, overlap_i=1, 6 valid beats after arming -> match_cnt_o sticks at 3.
//     clr_cnt_i on a match cycle -> match_cnt_o=1.
//   6 Feed 1,0,1; assert reset_i one cycle; feed 1
//     -> no pulse, armed_o=0, fill=1, all outputs at reset values the cycle after reset.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern and don't-care mask,
// valid qualification, overlap/non-overlap matching and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned       PAT_W       = 4,
    parameter int unsigned       CNT_W       = 8,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic             in_i,
    input  logic             overlap_i,
    input  logic             pat_load_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [PAT_W-1:0] mask_i,
    input  logic             clr_cnt_i,
    output logic             detected_o,
    output logic             armed_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam int unsigned        FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic {
        S_FILL,
        S_ARMED
    } state_t;

    state_t            state;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  mask;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  nxt;
    logic [FILL_W-1:0] fill_inc;
    logic              beat;
    logic              hit;

    // A load takes priority over the stream, so a load cycle is never a beat.
    always_comb begin
        nxt      = {hist[PAT_W-2:0], in_i};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        beat     = valid_i && !pat_load_i;
        hit      = beat && (fill_inc == FILL_FULL) && (((nxt ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= S_FILL;
            pat         <= DEFAULT_PAT;
            mask        <= '1;
            hist        <= '0;
            fill        <= '0;
            detected_o  <= 1'b0;
            match_cnt_o <= '0;
        end else begin
            detected_o <= hit;

            if (pat_load_i) begin
                pat   <= pat_i;
                mask  <= mask_i;
                hist  <= '0;
                fill  <= '0;
                state <= S_FILL;
            end else if (valid_i) begin
                if (hit && !overlap_i) begin
                    hist  <= '0;
                    fill  <= '0;
                    state <= S_FILL;
                end else begin
                    hist  <= nxt;
                    fill  <= fill_inc;
                    state <= (fill_inc == FILL_FULL) ? S_ARMED : S_FILL;
                end
            end

            // Clear wins over the old value but still counts a same-cycle match.
            if (clr_cnt_i) begin
                match_cnt_o <= hit ? CNT_W'(1) : '0;
            end else if (hit && (match_cnt_o != CNT_MAX)) begin
                match_cnt_o <= match_cnt_o + CNT_W'(1);
            end
        end
    end

    assign armed_o = (state == S_ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios then random traffic, checked
// against a queue-based model of the last PAT_W valid bits.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       valid_i = 1'b0;
    logic       in_i = 1'b0;
    logic       overlap_i = 1'b0;
    logic       pat_load_i = 1'b0;
    logic [3:0] pat_i = '0;
    logic [3:0] mask_i = '0;
    logic       clr_cnt_i = 1'b0;

    logic       det_a, armed_a;
    logic [7:0] cnt_a;
    logic       det_b, armed_b;
    logic [1:0] cnt_b;

    seq_detector_param #(.PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1011)) dut (
        .clk(clk), .reset_i(reset_i), .valid_i(valid_i), .in_i(in_i),
        .overlap_i(overlap_i), .pat_load_i(pat_load_i), .pat_i(pat_i),
        .mask_i(mask_i), .clr_cnt_i(clr_cnt_i), .detected_o(det_a),
        .armed_o(armed_a), .match_cnt_o(cnt_a)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2), .DEFAULT_PAT(4'b1011)) dut2 (
        .clk(clk), .reset_i(reset_i), .valid_i(valid_i), .in_i(in_i),
        .overlap_i(overlap_i), .pat_load_i(pat_load_i), .pat_i(pat_i),
        .mask_i(mask_i), .clr_cnt_i(clr_cnt_i), .detected_o(det_b),
        .armed_o(armed_b), .match_cnt_o(cnt_b)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: the valid bits seen since the last clear, oldest first.
    bit         q[$];
    bit [3:0]   m_pat  = 4'b1011;
    bit [3:0]   m_mask = 4'b1111;
    bit         e_det  = 1'b0;
    bit         e_armed = 1'b0;
    int         e_cnt8 = 0;
    int         e_cnt2 = 0;

    function automatic bit window_matches();
        if (q.size() < 4) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_mask[3-i] && (q[i] != m_pat[3-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit b, input bit ovl,
                        input bit ld, input bit [3:0] p, input bit [3:0] mk, input bit clr);
        bit m;
        @(negedge clk);
        reset_i = rst; valid_i = v; in_i = b; overlap_i = ovl;
        pat_load_i = ld; pat_i = p; mask_i = mk; clr_cnt_i = clr;
        @(posedge clk);
        m = 1'b0;
        if (rst) begin
            q.delete();
            m_pat = 4'b1011; m_mask = 4'b1111;
            e_cnt8 = 0; e_cnt2 = 0;
        end else begin
            if (ld) begin
                m_pat = p; m_mask = mk; q.delete();
            end else if (v) begin
                q.push_back(b);
                if (q.size() > 4) void'(q.pop_front());
                if (window_matches()) begin
                    m = 1'b1;
                    if (!ovl) q.delete();
                end
            end
            if (clr) begin
                e_cnt8 = m ? 1 : 0;
                e_cnt2 = m ? 1 : 0;
            end else if (m) begin
                e_cnt8 = (e_cnt8 < 255) ? e_cnt8 + 1 : 255;
                e_cnt2 = (e_cnt2 < 3) ? e_cnt2 + 1 : 3;
            end
        end
        e_det   = m;
        e_armed = (q.size() == 4);
        #1;
        chk("detected", 32'(det_a), 32'(e_det));
        chk("armed", 32'(armed_a), 32'(e_armed));
        chk("count", 32'(cnt_a), 32'(e_cnt8));
        chk("detected_w2", 32'(det_b), 32'(e_det));
        chk("armed_w2", 32'(armed_b), 32'(e_armed));
        chk("count_w2", 32'(cnt_b), 32'(e_cnt2));
    endtask

    task automatic beat(input bit b, input bit ovl);
        step(1'b0, 1'b1, b, ovl, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic load(input bit [3:0] p, input bit [3:0] mk, input bit v, input bit b);
        step(1'b0, v, b, 1'b0, 1'b1, p, mk, 1'b0);
    endtask

    initial begin
        bit [6:0] s7;
        bit [3:0] s4;
        int       pulses;
        s7 = 7'b1011011;

        // Reset values
        do_reset();
        do_reset();
        chk("reset_det", 32'(det_a), 32'd0);
        chk("reset_armed", 32'(armed_a), 32'd0);
        chk("reset_cnt", 32'(cnt_a), 32'd0);

        // 1: non-overlapping, 1011011 -> one pulse after beat 4
        pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            beat(s7[i], 1'b0);
            if (i == 3) chk("t1_pulse_beat4", 32'(det_a), 32'd1);
            pulses += int'(det_a);
        end
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_cnt", 32'(cnt_a), 32'd1);

        // 2: overlapping -> pulses after beats 4 and 7
        do_reset();
        pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            beat(s7[i], 1'b1);
            if (i <= 3) chk("t2_armed", 32'(armed_a), 32'd1);
            pulses += int'(det_a);
        end
        chk("t2_last_pulse", 32'(det_a), 32'd1);
        chk("t2_pulses", 32'(pulses), 32'd2);
        chk("t2_cnt", 32'(cnt_a), 32'd2);

        // 3: gaps of two invalid cycles between bits
        do_reset();
        s4 = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            beat(s4[i], 1'b0);
            if (i == 0) chk("t3_pulse", 32'(det_a), 32'd1);
            idle();
            idle();
        end
        chk("t3_cnt", 32'(cnt_a), 32'd1);

        // 4: loaded pattern with don't-care
        do_reset();
        load(4'b1001, 4'b1101, 1'b0, 1'b0);
        s4 = 4'b1001;
        for (int i = 3; i >= 0; i--) beat(s4[i], 1'b0);
        chk("t4_first", 32'(det_a), 32'd1);
        s4 = 4'b1011;
        for (int i = 3; i >= 0; i--) beat(s4[i], 1'b0);
        chk("t4_second", 32'(det_a), 32'd1);
        s4 = 4'b0001;
        for (int i = 3; i >= 0; i--) beat(s4[i], 1'b0);
        chk("t4_no_pulse", 32'(det_a), 32'd0);
        chk("t4_cnt", 32'(cnt_a), 32'd2);
        load(4'b1001, 4'b1101, 1'b1, 1'b1);
        chk("t4_load_armed", 32'(armed_a), 32'd0);
        chk("t4_load_det", 32'(det_a), 32'd0);

        // 5: mask=0, overlapping, narrow counter saturates, clear on match gives 1
        do_reset();
        load(4'b0000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) beat(1'($urandom_range(1)), 1'b1);
        chk("t5_sat", 32'(cnt_b), 32'd3);
        chk("t5_cnt8", 32'(cnt_a), 32'd7);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        chk("t5_clr_match", 32'(cnt_b), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        chk("t5_clr_only", 32'(cnt_a), 32'd0);

        // 6: reset mid-pattern
        do_reset();
        beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
        do_reset();
        chk("t6_det", 32'(det_a), 32'd0);
        chk("t6_armed", 32'(armed_a), 32'd0);
        chk("t6_cnt", 32'(cnt_a), 32'd0);
        beat(1'b1, 1'b0);
        chk("t6_no_pulse", 32'(det_a), 32'd0);
        chk("t6_not_armed", 32'(armed_a), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit [3:0] mk;
            mk = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b1111;
            step(($urandom_range(99) == 0),
                 ($urandom_range(3) != 0),
                 1'($urandom),
                 1'($urandom),
                 ($urandom_range(39) == 0),
                 4'($urandom), mk,
                 ($urandom_range(29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
